// File: rtl/param_reg_bank_if.sv
// Parameter-bank bus: write strobe, clear and data in; read port, flat view and status out.
// Ports: enable, params_reg_enable, clear, data_in, rd_addr (to bank);
//        rd_data, params_flat, wr_ptr, params_ready, overflow, load_done (from bank).
interface param_reg_bank_if #(
    parameter int NUM_PARAMS = 8,
    parameter int WIDTH      = 8,
    parameter int PTR_W      = 4
);
    logic                        enable;
    logic                        params_reg_enable;
    logic                        clear;
    logic [WIDTH-1:0]            data_in;
    logic [PTR_W-1:0]            rd_addr;
    logic [WIDTH-1:0]            rd_data;
    logic [NUM_PARAMS*WIDTH-1:0] params_flat;
    logic [PTR_W-1:0]            wr_ptr;
    logic                        params_ready;
    logic                        overflow;
    logic                        load_done;

    // Master: the memory control unit / neuron datapath side.
    modport master (
        output enable,
        output params_reg_enable,
        output clear,
        output data_in,
        output rd_addr,
        input  rd_data,
        input  params_flat,
        input  wr_ptr,
        input  params_ready,
        input  overflow,
        input  load_done
    );

    // Slave: the register bank itself.
    modport slave (
        input  enable,
        input  params_reg_enable,
        input  clear,
        input  data_in,
        input  rd_addr,
        output rd_data,
        output params_flat,
        output wr_ptr,
        output params_ready,
        output overflow,
        output load_done
    );
endinterface

// File: rtl/param_reg_bank.sv
// Parameter register bank: each accepted strobe stores data_in into the next slot until full.
// Latency: one cycle from strobe edge to slot/pointer/flags; rd_data is combinational.
// Backpressure: none; one write per cycle, writes while full are dropped and set sticky overflow.
// Ports: clk, rst (async active-high), bus (param_reg_bank_if.slave).
module param_reg_bank #(
    parameter int NUM_PARAMS = 8,
    parameter int WIDTH      = 8,
    parameter int PTR_W      = 4
) (
    input  logic               clk,
    input  logic               rst,
    param_reg_bank_if.slave    bus
);

    // Load-sequence state; always consistent with the pointer value.
    typedef enum logic [1:0] {
        ST_EMPTY   = 2'd0,
        ST_FILLING = 2'd1,
        ST_FULL    = 2'd2
    } state_t;

    localparam logic [PTR_W-1:0] PTR_FULL = PTR_W'(NUM_PARAMS);

    state_t           state_q, state_d;
    logic [PTR_W-1:0] ptr_q, ptr_d;
    logic [WIDTH-1:0] slot_q [NUM_PARAMS];
    logic [WIDTH-1:0] slot_d [NUM_PARAMS];
    logic             ready_q, ready_d;
    logic             ovf_q, ovf_d;
    logic             done_q, done_d;

    logic             strobe;
    logic             do_clear;
    logic             accept;
    logic             reject;

    // ------------------------------------------------------------------
    // Control decode. Clear has priority over a coincident strobe, and
    // nothing happens while the stage is disabled.
    // ------------------------------------------------------------------
    always_comb begin
        do_clear = bus.enable && bus.clear;
        strobe   = bus.enable && bus.params_reg_enable && !bus.clear;
        accept   = strobe && (state_q != ST_FULL);
        reject   = strobe && (state_q == ST_FULL);
    end

    // ------------------------------------------------------------------
    // Next-state / next-value logic.
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        slot_d  = slot_q;
        ovf_d   = ovf_q;

        if (do_clear) begin
            ptr_d = '0;
            ovf_d = 1'b0;
            for (int i = 0; i < NUM_PARAMS; i++) begin
                slot_d[i] = '0;
            end
        end else if (accept) begin
            for (int i = 0; i < NUM_PARAMS; i++) begin
                if (ptr_q == PTR_W'(i)) begin
                    slot_d[i] = bus.data_in;
                end
            end
            ptr_d = ptr_q + PTR_W'(1);
        end else if (reject) begin
            ovf_d = 1'b1;
        end

        // State follows the pointer it will hold after this edge.
        if (ptr_d == '0) begin
            state_d = ST_EMPTY;
        end else if (ptr_d == PTR_FULL) begin
            state_d = ST_FULL;
        end else begin
            state_d = ST_FILLING;
        end

        // Ready rises on the same edge as the final write; done marks
        // only the 0->1 transition and is forced low while disabled.
        ready_d = (state_d == ST_FULL);
        done_d  = bus.enable && ready_d && !ready_q;
    end

    // ------------------------------------------------------------------
    // State registers.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_EMPTY;
            ptr_q   <= '0;
            ready_q <= 1'b0;
            ovf_q   <= 1'b0;
            done_q  <= 1'b0;
            for (int i = 0; i < NUM_PARAMS; i++) begin
                slot_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            ready_q <= ready_d;
            ovf_q   <= ovf_d;
            done_q  <= done_d;
            for (int i = 0; i < NUM_PARAMS; i++) begin
                slot_q[i] <= slot_d[i];
            end
        end
    end

    // ------------------------------------------------------------------
    // Read side: flat view and addressed read. Out-of-range addresses
    // return zero rather than aliasing onto a real slot.
    // ------------------------------------------------------------------
    always_comb begin
        bus.params_flat = '0;
        for (int i = 0; i < NUM_PARAMS; i++) begin
            bus.params_flat[i*WIDTH +: WIDTH] = slot_q[i];
        end
    end

    always_comb begin
        bus.rd_data = '0;
        for (int i = 0; i < NUM_PARAMS; i++) begin
            if (bus.rd_addr == PTR_W'(i)) begin
                bus.rd_data = slot_q[i];
            end
        end
    end

    assign bus.wr_ptr       = ptr_q;
    assign bus.params_ready = ready_q;
    assign bus.overflow     = ovf_q;
    assign bus.load_done    = done_q;

endmodule

// File: doc/param_reg_bank.md
# param_reg_bank

Parameter register bank for the RSNN core. Sits directly downstream of the memory control unit and consumes its one-cycle `params_reg_enable` write strobe. Each strobe captures one byte from the parameter input bus into the next slot of an indexed register file. Once all slots are filled, the bank flags the parameter set as ready, and the neuron datapath reads the stored values in flat or addressed form.

## Interface
Parameters:
- `NUM_PARAMS`, default 8: number of parameter slots (≥2).
- `WIDTH`, default 8: bits per parameter.
- `PTR_W`, default 4: pointer width, equal to $clog2(NUM_PARAMS+1).

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `enable`  in  1  global stage enable; when low, all state holds.
- `params_reg_enable`  in  1  write strobe from the memory control unit. One write per high cycle.
- `clear`  in  1  synchronous restart of the load sequence.
- `data_in`  in  WIDTH  parameter value to capture.
- `rd_addr`  in  PTR_W  read index.
- `rd_data`  out  WIDTH  slot `rd_addr`, combinational; 0 when `rd_addr` ≥ NUM_PARAMS.
- `params_flat`  out  NUM_PARAMS*WIDTH  all slots; slot i at bits [i*WIDTH +: WIDTH].
- `wr_ptr`  out  PTR_W  number of slots written since the last reset or clear (0..NUM_PARAMS).
- `params_ready`  out  1  high when `wr_ptr` == NUM_PARAMS.
- `overflow`  out  1  sticky flag: a write was attempted while the bank was full.
- `load_done`  out  1  one-cycle pulse on the cycle `params_ready` first rises.

## Operation
- Storage: NUM_PARAMS × WIDTH registers. The write pointer counts from 0 to NUM_PARAMS and never wraps.
- States, derived from the pointer:
  - EMPTY: `wr_ptr` = 0.
  - FILLING: 0 < `wr_ptr` < NUM_PARAMS.
  - FULL: `wr_ptr` = NUM_PARAMS.
- A write is accepted when `enable` && `params_reg_enable` && !`clear` && not FULL. On an accepted write:
  - slot[`wr_ptr`] ← `data_in`;
  - `wr_ptr` ← `wr_ptr` + 1.
- Write while FULL (with `enable`, strobe high, `clear` low):
  - no slot changes;
  - `wr_ptr` holds;
  - `overflow` ← 1. It stays set until reset or clear.
- `clear` with `enable` high:
  - `wr_ptr` ← 0; all slots ← 0;
  - `overflow` ← 0; `params_ready` ← 0.
  - A simultaneous strobe is dropped; clear has priority.
- `enable` low: strobe and `clear` are ignored. Slots, pointer, and flags hold. `load_done` is 0.
- A strobe held high for k cycles performs k writes. No edge detection is done here; the upstream unit guarantees single-cycle pulses.
- Reset (asynchronous, any time, including mid-load):
  - all slots = 0, `wr_ptr` = 0;
  - `params_ready` = 0, `overflow` = 0, `load_done` = 0.
  - `rd_data` = 0 and `params_flat` = 0 while reset is held.
- `params_ready` is registered. It rises on the same edge where the final write makes `wr_ptr` = NUM_PARAMS.
- `load_done` is a registered pulse. It is 1 for exactly the one cycle following the edge on which `params_ready` transitions 0→1.

## Timing
- Write latency is one cycle: the strobe is sampled at edge N. The slot value, `wr_ptr`, and `params_flat` are updated after edge N.
- `rd_data` is a combinational function of the registers and `rd_addr`. A same-cycle read of the slot being written returns the old value.
- `params_ready` and `load_done` are valid after the edge of the NUM_PARAMS-th accepted write. There is no extra pipeline stage.
- `overflow` is set after the edge of the first rejected write.
- `clear` takes effect at the next edge. All outputs show cleared values in the following cycle.
- Back-to-back strobes are supported: one write per cycle, with no stall and no ready/valid back-pressure.

## Test plan
- **Reset mid-load:** reset, write 0x11, 0x22, 0x33, then assert `rst` asynchronously between edges.
  - `wr_ptr`, `params_flat`, and all flags read 0 immediately.
  - A subsequent write of 0xAA lands in slot 0.
- **Full load:** apply 8 single-cycle strobes with data 0x01..0x08, separated by idle cycles.
  - `params_flat` = 0x0807060504030201.
  - `params_ready` = 1 after the 8th edge.
  - `load_done` high for exactly one cycle.
  - `rd_addr` = 3 gives `rd_data` = 0x04.
  - `rd_addr` = 9 gives `rd_data` = 0.
- **Overflow:** after a full load, strobe with `data_in` = 0xFF.
  - Slots unchanged, `wr_ptr` = 8, `overflow` = 1.
  - A second strobe leaves `load_done` at 0.
- **Clear vs write:** with `wr_ptr` = 5, assert `clear` and the strobe in the same cycle with 0x5A.
  - `wr_ptr` = 0, all slots 0, `overflow` = 0, and 0x5A is not stored.
- **Enable gating:** with `enable` = 0, pulse the strobe 3 times and `clear` once.
  - No change to the pointer, slots, or flags.
  - Re-enable and write 0x77: it lands at the prior `wr_ptr`.
- **Back-to-back:** hold the strobe for 8 consecutive cycles with incrementing data 0x10..0x17.
  - All 8 slots are filled and `params_ready` = 1 after the 8th edge.
  - A 9th consecutive cycle sets `overflow`.
